// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-mux
// encodings, the PC register index, the memory-wait FSM state type and the
// operand forwarding selection helper.
package hazard_pkg;

  // E-stage operand mux encodings
  localparam logic [1:0] FWD_RF = 2'b00;  // register file read value
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

  // r15 reads return PC+8 from the datapath and must never be forwarded
  localparam logic [3:0] REG_PC = 4'd15;

  // Memory-wait sequencer states
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Forwarding select for one E-stage source register; M wins over W
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic [3:0] wa_w,
    input logic       we_m,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (ra == wa_m) && (ra != REG_PC)) begin
      sel = FWD_M;
    end else if (we_w && (ra == wa_w) && (ra != REG_PC)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Performance counters for the hazard controller: stall cycles, flush cycles
// and data-memory wait cycles. Each counter wraps at 2^CNT_WIDTH.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 memwait_i,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o,
  output logic [CNT_WIDTH-1:0] memwait_cnt_o
);

  logic [CNT_WIDTH-1:0] stall_cnt_q,   stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q,   flush_cnt_d;
  logic [CNT_WIDTH-1:0] memwait_cnt_q, memwait_cnt_d;

  // Next counter values: add one for each event seen this cycle
  always_comb begin
    stall_cnt_d   = stall_cnt_q   + CNT_WIDTH'(stall_i);
    flush_cnt_d   = flush_cnt_q   + CNT_WIDTH'(flush_i);
    memwait_cnt_d = memwait_cnt_q + CNT_WIDTH'(memwait_i);
  end

  // Counter registers, cleared by the asynchronous reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign memwait_cnt_o = memwait_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core (F, D, E, M, W).
// Produces stall enables, synchronous flushes and E-stage forwarding selects,
// and sequences data-memory waits with a sticky timeout watchdog.
// Optional feature macro: HAZARD_PERF_EN (performance counters; without it
// the counter ports are tied to zero).
//
// Handshake: a data-memory access is presented by memreqm; the memory
// completes it in the cycle dmem_ready is high. Every cycle with memreqm high
// and dmem_ready low is a wait cycle that freezes the whole pipeline and
// pushes a bubble into W; the access retires in the dmem_ready cycle.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           ra1d,
  input  logic [3:0]           ra2d,
  input  logic [3:0]           ra1e,
  input  logic [3:0]           ra2e,
  input  logic [3:0]           wa3e,
  input  logic [3:0]           wa3m,
  input  logic [3:0]           wa3w,
  input  logic                 regwritem,
  input  logic                 regwritew,
  input  logic                 memtorege,
  input  logic                 pcsrcd,
  input  logic                 pcsrce,
  input  logic                 pcsrcm,
  input  logic                 pcsrcw,
  input  logic                 branchtakene,
  input  logic                 memreqm,
  input  logic                 dmem_ready,
  output logic [1:0]           forwardae,
  output logic [1:0]           forwardbe,
  output logic                 stallf,
  output logic                 stalld,
  output logic                 stalle,
  output logic                 stallm,
  output logic                 flushd,
  output logic                 flushe,
  output logic                 flushw,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] memwait_cnt,
  output logic                 dbg_state   // 1 while the memory FSM is in WAIT
);

  // Wait counter saturates at MEM_TIMEOUT, so it only needs to hold that value
  localparam int              WCW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]  TO_VAL = WCW'(MEM_TIMEOUT);
  localparam logic [WCW-1:0]  ONE    = WCW'(1);

  logic ldrstall;
  logic pcwrpend;
  logic memstall;

  mem_state_e     state_q, state_d;
  logic [WCW-1:0] wcnt_q,  wcnt_d;
  logic           timeout_q, timeout_d;

  // Operand forwarding is independent of stalls and always follows the inputs
  assign forwardae = fwd_sel(ra1e, wa3m, wa3w, regwritem, regwritew);
  assign forwardbe = fwd_sel(ra2e, wa3m, wa3w, regwritem, regwritew);

  // Hazard detection and stall/flush generation; a memory wait overrides all
  always_comb begin
    ldrstall = memtorege & ((ra1d == wa3e) | (ra2d == wa3e));
    pcwrpend = pcsrcd | pcsrce | pcsrcm;
    memstall = memreqm & ~dmem_ready;

    stallf = ldrstall | pcwrpend;
    stalld = ldrstall;
    stalle = 1'b0;
    stallm = 1'b0;
    flushd = pcwrpend | pcsrcw | branchtakene;
    flushe = ldrstall | branchtakene;
    flushw = 1'b0;

    if (memstall) begin
      // Freeze F..M and drop a bubble into W; nothing ahead may be flushed,
      // otherwise the held instructions would be lost
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      stallm = 1'b1;
      flushd = 1'b0;
      flushe = 1'b0;
      flushw = 1'b1;
    end
  end

  // Memory-wait FSM state, wait counter and sticky watchdog flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: WAIT persists while the access is still stalled; both
  // dmem_ready and an (illegal) drop of memreqm end the stall
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = WAIT;
          wcnt_d  = ONE;
        end
      end
      WAIT: begin
        if (memstall) begin
          wcnt_d = (wcnt_q >= TO_VAL) ? TO_VAL : (wcnt_q + ONE);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
    // Counter reaches MEM_TIMEOUT on the edge ending that many wait cycles
    timeout_d = timeout_q | (memstall & (wcnt_d == TO_VAL));
  end

  assign mem_timeout = timeout_q;
  assign dbg_state   = (state_q == WAIT);

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf_cnt (
    .clk_i         (clk),
    .reset_i       (reset),
    .stall_i       (stallf),
    .flush_i       (flushd | flushe),
    .memwait_i     (memstall),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt),
    .memwait_cnt_o (memwait_cnt)
  );
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural reference model.
module tb_hazard_ctrl;

  localparam int MEM_TO = 4;
  localparam int CW     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  logic regwritem, regwritew, memtorege;
  logic pcsrcd, pcsrce, pcsrcm, pcsrcw, branchtakene, memreqm, dmem_ready;
  logic [1:0] forwardae, forwardbe;
  logic stallf, stalld, stalle, stallm, flushd, flushe, flushw, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;
  logic dbg_state;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
    .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w),
    .regwritem(regwritem), .regwritew(regwritew), .memtorege(memtorege),
    .pcsrcd(pcsrcd), .pcsrce(pcsrce), .pcsrcm(pcsrcm), .pcsrcw(pcsrcw),
    .branchtakene(branchtakene), .memreqm(memreqm), .dmem_ready(dmem_ready),
    .forwardae(forwardae), .forwardbe(forwardbe),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
    .flushd(flushd), .flushe(flushe), .flushw(flushw),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int            run_len;      // consecutive wait cycles completed so far
  bit            to_flag;
  bit            in_wait;      // a wait cycle preceded the last edge
  logic [CW-1:0] m_stall, m_flush, m_memwait;

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (regwritem && ra == wa3m && ra != 4'd15) return 2'd2;
    if (regwritew && ra == wa3w && ra != 4'd15) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_clear();
    run_len = 0; to_flag = 0; in_wait = 0;
    m_stall = '0; m_flush = '0; m_memwait = '0;
  endtask

  // Check every output for the current inputs, then clock once and advance
  task automatic step(input string tag);
    bit ldr, pcw, ms;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    #1;
    ldr = memtorege && (ra1d == wa3e || ra2d == wa3e);
    pcw = pcsrcd || pcsrce || pcsrcm;
    ms  = memreqm && !dmem_ready;
    if (ms) begin
      {e_sf, e_sd, e_se, e_sm} = 4'b1111;
      {e_fd, e_fe, e_fw}       = 3'b001;
    end else begin
      e_sf = ldr || pcw; e_sd = ldr; e_se = 0; e_sm = 0;
      e_fd = pcw || pcsrcw || branchtakene; e_fe = ldr || branchtakene; e_fw = 0;
    end
    check({tag, ".fwda"}, 64'(forwardae), 64'(ref_fwd(ra1e)));
    check({tag, ".fwdb"}, 64'(forwardbe), 64'(ref_fwd(ra2e)));
    check({tag, ".stalls"}, 64'({stallf, stalld, stalle, stallm}), 64'({e_sf, e_sd, e_se, e_sm}));
    check({tag, ".flushes"}, 64'({flushd, flushe, flushw}), 64'({e_fd, e_fe, e_fw}));
    check({tag, ".timeout"}, 64'(mem_timeout), 64'(to_flag));
    check({tag, ".state"}, 64'(dbg_state), 64'(in_wait));
`ifdef HAZARD_PERF_EN
    check({tag, ".cnts"}, {16'h0, stall_cnt, flush_cnt, memwait_cnt}, {16'h0, m_stall, m_flush, m_memwait});
`else
    check({tag, ".cnts"}, {16'h0, stall_cnt, flush_cnt, memwait_cnt}, 64'h0);
`endif
    @(posedge clk);
    if (!reset) begin
      in_wait = ms;
      run_len = ms ? run_len + 1 : 0;
      if (run_len >= MEM_TO) to_flag = 1;
      m_stall   = m_stall   + CW'(e_sf);
      m_flush   = m_flush   + CW'(e_fd || e_fe);
      m_memwait = m_memwait + CW'(ms);
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w} = '0;
    {regwritem, regwritew, memtorege} = '0;
    {pcsrcd, pcsrce, pcsrcm, pcsrcw, branchtakene, memreqm, dmem_ready} = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check("reset.timeout", 64'(mem_timeout), 64'(0));
    check("reset.state", 64'(dbg_state), 64'(0));
    check("reset.cnts", {16'h0, stall_cnt, flush_cnt, memwait_cnt}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_random();
    ra1d = 4'($urandom_range(0, 3)); ra2d = 4'($urandom_range(0, 3));
    ra1e = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    ra2e = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    wa3e = 4'($urandom_range(0, 3));
    wa3m = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    wa3w = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    regwritem = 1'($urandom); regwritew = 1'($urandom);
    memtorege = ($urandom_range(0, 3) == 0);
    pcsrcd = ($urandom_range(0, 7) == 0); pcsrce = ($urandom_range(0, 7) == 0);
    pcsrcm = ($urandom_range(0, 7) == 0); pcsrcw = ($urandom_range(0, 7) == 0);
    branchtakene = ($urandom_range(0, 5) == 0);
    memreqm = ($urandom_range(0, 2) != 0);
    dmem_ready = ($urandom_range(0, 3) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    apply_reset();

    // Forward priority
    ra1e = 4'd3; wa3m = 4'd3; wa3w = 4'd3; regwritem = 1; regwritew = 1;
    #1 check("fwd_m_prio", 64'(forwardae), 64'(2'b10));
    step("fwd_m");
    regwritem = 0;
    #1 check("fwd_w", 64'(forwardae), 64'(2'b01));
    step("fwd_w");
    regwritem = 1; ra1e = 4'd15; wa3m = 4'd15; wa3w = 4'd15;
    #1 check("fwd_pc", 64'(forwardae), 64'(2'b00));
    step("fwd_pc");
    drive_idle();

    // Load-use: one cycle of stall + E bubble, then clear
    memtorege = 1; wa3e = 4'd5; ra2d = 4'd5; ra1d = 4'd1;
    #1 check("ldr.hazard", 64'({stallf, stalld, flushe}), 64'(3'b111));
    step("ldr1");
    drive_idle(); ra1d = 4'd1; ra2d = 4'd5; wa3e = 4'd5;
    #1 check("ldr.after", 64'({stallf, stalld, flushe}), 64'(3'b000));
    step("ldr2");
    drive_idle();

    // Taken branch
    branchtakene = 1;
    #1 check("br", 64'({flushd, flushe, stallf}), 64'(3'b110));
    step("br");
    drive_idle();

    // Memory wait of 3 cycles then ready
    memreqm = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw.hold", 64'({stallf, stalld, stalle, stallm, flushw}), 64'(5'b11111));
      step("mw");
    end
    dmem_ready = 1;
    #1 check("mw.release", 64'({stalle, flushw}), 64'(2'b00));
`ifdef HAZARD_PERF_EN
    check("mw.cnt", 64'(memwait_cnt), 64'(3));
`else
    check("mw.cnt", 64'(memwait_cnt), 64'(0));
`endif
    step("mw_rdy");
    drive_idle();
    #1 check("mw.run", 64'(dbg_state), 64'(0));
    step("mw_idle");

    // Watchdog: rises after the 4th wait edge, sticky, cleared by reset
    memreqm = 1;
    for (int i = 1; i <= 5; i++) begin
      step("wd");
      check("wd.flag", 64'(mem_timeout), 64'(i >= MEM_TO));
    end
    dmem_ready = 1;
    step("wd_rdy");
    check("wd.sticky", 64'(mem_timeout), 64'(1));
    dmem_ready = 0;
    step("wd_wait");
    apply_reset();   // aborts the wait in progress
    drive_idle();
    step("wd_cleared");

    // Memory stall overriding a taken branch
    memreqm = 1; branchtakene = 1; pcsrce = 1;
    #1 check("ms_br", 64'({flushd, flushe, stalle}), 64'(3'b001));
    step("ms_br");
    drive_idle();
    step("ms_br_end");

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if ($urandom_range(0, 99) == 0) apply_reset();
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage ARM core (F, D, E, M, W). It drives the enable (stall) and synchronous-clear (flush) inputs of the inter-stage pipeline registers and the E-stage operand forwarding muxes. It also sequences multi-cycle data-memory waits through a small FSM with a timeout watchdog. It sits beside the datapath and owns no architectural state.

## Interface
Parameters:
- MEM_TIMEOUT, 64: wait cycles before `mem_timeout` sets; must be ≥ 1.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ra1d, ra2d  in  4  D-stage source register addresses.
- ra1e, ra2e  in  4  E-stage source register addresses.
- wa3e, wa3m, wa3w  in  4  destination register addresses in E, M and W.
- regwritem, regwritew  in  1  register write enable in M and W.
- memtorege  in  1  E-stage instruction is a load.
- pcsrcd, pcsrce, pcsrcm, pcsrcw  in  1  instruction in that stage writes the PC.
- branchtakene  in  1  branch resolved taken in E.
- memreqm  in  1  M-stage data-memory access is active.
- dmem_ready  in  1  data memory completes the access this cycle.
- forwardae, forwardbe  out  2  E operand select: 00 register file, 01 W result, 10 M ALU result.
- stallf, stalld, stalle, stallm  out  1  hold the named stage register.
- flushd, flushe, flushw  out  1  synchronous clear of the D, E and W input registers.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_WIDTH  performance counters.

## Operation
- Forwarding (combinational), per source register X in {1,2}:
  - Select 10 if `regwritem` is set, `raXe == wa3m` and `raXe != 15`.
  - Otherwise select 01 if `regwritew` is set, `raXe == wa3w` and `raXe != 15`.
  - Otherwise select 00.
  - The M stage has priority over the W stage.
- Load-use hazard: `ldrstall = memtorege & (ra1d == wa3e | ra2d == wa3e)`.
- PC write pending: `pcwrpend = pcsrcd | pcsrce | pcsrcm`.
- Memory stall: `memstall = memreqm & ~dmem_ready`. This is a Mealy output, active in the same cycle as the request.
- Output rules when `memstall = 0`:
  - `stallf = ldrstall | pcwrpend`
  - `stalld = ldrstall`
  - `stalle = stallm = 0`
  - `flushd = pcwrpend | pcsrcw | branchtakene`
  - `flushe = ldrstall | branchtakene`
  - `flushw = 0`
- Output rules when `memstall = 1`, which dominates every other rule:
  - `stallf = stalld = stalle = stallm = 1`
  - `flushd = flushe = 0`
  - `flushw = 1`, which inserts a bubble into W.
  - Forwarding continues to be computed from the inputs.
- FSM states:
  - RUN: on `memstall`, go to WAIT and load the wait counter with 1.
  - WAIT: on `dmem_ready`, return to RUN. Otherwise increment the counter, saturating at MEM_TIMEOUT.
  - `memreqm` dropping while in WAIT (which is illegal) also returns the FSM to RUN.
- Watchdog: `mem_timeout` sets on the edge at which the counter equals MEM_TIMEOUT while in WAIT. It stays set until reset. Stalling continues regardless of the flag.
- Reset: FSM goes to RUN, the wait counter to 0, `mem_timeout` to 0 and all performance counters to 0. The combinational outputs follow the inputs, which are zero because the pipeline registers also reset.
- Reset asserted during WAIT aborts the wait immediately.

## Timing
- All stall, flush and forward outputs are combinational from the inputs in the same cycle. The flushes act on the next clock edge, because the register clear is synchronous.
- A load-use hazard costs exactly 1 bubble in E.
- A taken branch flushes D and E on the edge ending the branch's E cycle.
- Memory wait: N cycles of `memreqm` with `dmem_ready` low, followed by one cycle with `dmem_ready` high:
  - The pipeline holds for N cycles.
  - W receives N bubbles.
  - The FSM is back in RUN one edge after `dmem_ready` is high.
- `mem_timeout` rises on the edge that ends the MEM_TIMEOUT-th consecutive wait cycle.

## Configuration
- HAZARD_PERF_EN defined, each counter increments by 1 per cycle with wrap-around at 2^CNT_WIDTH:
  - `stall_cnt`: cycles with `stallf` set.
  - `flush_cnt`: cycles with `flushd` or `flushe` set.
  - `memwait_cnt`: cycles with `memstall` set.
- HAZARD_PERF_EN undefined: counter logic is absent, the counter ports remain and are tied to 0.

## Structure
- Shared package `hazard_pkg` holds:
  - Forwarding encodings FWD_RF = 00, FWD_W = 01, FWD_M = 10.
  - The constant REG_PC = 15.
  - The FSM state type (RUN, WAIT).
- Sub-module `hazard_perf_cnt` contains the three counters. It is instantiated only under HAZARD_PERF_EN.

## Test plan
- Forward priority: `ra1e = 3`, `wa3m = 3`, `wa3w = 3`, both regwrites set → `forwardae = 10`. Same setup with `regwritem = 0` → `01`. With `ra1e = 15` → `00`.
- Load-use: `memtorege = 1`, `wa3e = 5`, `ra2d = 5` → `stallf = 1`, `stalld = 1`, `flushe = 1` for one cycle, then all 0.
- Taken branch: `branchtakene = 1` → `flushd = 1`, `flushe = 1`, `stallf = 0` in that cycle.
- Memory wait: `memreqm = 1` with `dmem_ready = 0` for 3 cycles, then 1 → all four stalls and `flushw` high for exactly 3 cycles. `memwait_cnt = 3` with HAZARD_PERF_EN defined, 0 without.
- Watchdog: MEM_TIMEOUT = 4, `dmem_ready` held at 0 → `mem_timeout` rises after the 4th wait edge and stays set after `dmem_ready` goes to 1. Asserting reset clears it.
- Memory stall overriding a branch: `memstall` and `branchtakene` high together → `flushd = 0`, `flushe = 0`, `stalle = 1`.
